stage_sequencer: RTL and testbench

Multicycle stage controller for the single-issue CPU core. It generates the one-hot stage strobes `stateIF`, `stateID`, `stateEXE`, `stateMEM` and `stateWB` that gate the PC, program memory, register file, ALU and data memory enables. It skips stages that the current instruction class does not need, stalls in MEM until data memory signals ready, and halts on system or illegal opcodes. It also keeps a retired-instruction count for debug.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/stage_sequencer_if.sv | 34 +++
 rtl/stage_sequencer_op_classify.sv | 34 +++
 rtl/stage_sequencer.sv | 115 +++++++++++
 tb/tb_stage_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the core control blocks.
//   - Opcode constants for the instruction classes the core executes.
//   - seq_state_t: state encoding of the multicycle stage sequencer.
package cpu_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_EXE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: signal bundle between the stage sequencer and the core.
//   master modport (core side): drives run, opcode, mem_ready; observes strobes
//                               and status.
//   slave modport (sequencer):  the reverse.
//   CNT_W sets the width of retired_cnt.
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             stateIF;
    logic             stateID;
    logic             stateEXE;
    logic             stateMEM;
    logic             stateWB;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output run, opcode, mem_ready,
        input  stateIF, stateID, stateEXE, stateMEM, stateWB,
        input  busy, halted, illegal, retire, retired_cnt
    );

    modport slave (
        input  run, opcode, mem_ready,
        output stateIF, stateID, stateEXE, stateMEM, stateWB,
        output busy, halted, illegal, retire, retired_cnt
    );
endinterface

// File: rtl/stage_sequencer_op_classify.sv
// op_classify: combinational opcode decoder.
//   opcode     : 7-bit major opcode.
//   needs_mem  : instruction visits the MEM stage (load, store).
//   needs_wb   : instruction visits the WB stage (R-type, I-ALU, load).
//   is_system  : system opcode, stops the sequencer without error.
//   is_illegal : opcode not recognised by the core.
module op_classify
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       needs_mem,
    output logic       needs_wb,
    output logic       is_system,
    output logic       is_illegal
);
    always_comb begin
        needs_mem  = 1'b0;
        needs_wb   = 1'b0;
        is_system  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE,
            OP_IALU:   needs_wb  = 1'b1;
            OP_LOAD: begin
                needs_mem = 1'b1;
                needs_wb  = 1'b1;
            end
            OP_STORE:  needs_mem = 1'b1;
            OP_BRANCH: ;  // completes in EXE
            OP_SYSTEM: is_system = 1'b1;
            default:   is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle stage controller for the single-issue core.
//   clk   : core clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : stage_sequencer_if.slave -- run/opcode/mem_ready in, one-hot
//           stage strobes, busy/halted/illegal status, retire pulse and
//           retired-instruction counter out.
// Stages not needed by the instruction class are skipped, MEM stalls until
// mem_ready, and system/illegal opcodes park the machine in HALT.
module stage_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    stage_sequencer_if.slave   bus
);
    seq_state_t       state_reg, state_next;
    logic [6:0]       op_q_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             retire_c;
    logic             load_op;
    logic             set_illegal;
    logic             end_instr;

    // One decoder serves both phases: in ID it looks at the live opcode,
    // afterwards at the latched copy (opcode may change after ID).
    logic [6:0] classify_in;
    logic       needs_mem, needs_wb, is_system, is_illegal;

    assign classify_in = (state_reg == ST_ID) ? bus.opcode : op_q_reg;

    op_classify u_classify (
        .opcode     (classify_in),
        .needs_mem  (needs_mem),
        .needs_wb   (needs_wb),
        .is_system  (is_system),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_q_reg    <= 7'd0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (load_op)
                op_q_reg <= bus.opcode;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (retire_c)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state_reg;
        load_op     = 1'b0;
        set_illegal = 1'b0;
        end_instr   = 1'b0;
        retire_c    = 1'b0;

        case (state_reg)
            ST_IDLE: if (bus.run) state_next = ST_IF;
            ST_IF:   state_next = ST_ID;
            ST_ID: begin
                if (is_system) begin
                    state_next = ST_HALT;
                end else if (is_illegal) begin
                    state_next  = ST_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_next = ST_EXE;
                    load_op    = 1'b1;
                end
            end
            ST_EXE: begin
                if (needs_mem)     state_next = ST_MEM;
                else if (needs_wb) state_next = ST_WB;
                else               end_instr  = 1'b1;
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (needs_wb) state_next = ST_WB;
                    else          end_instr  = 1'b1;
                end
            end
            ST_WB:   end_instr  = 1'b1;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase

        // Final stage of an instruction: retire and fetch again without a
        // bubble, or park in IDLE if run has been dropped.
        if (end_instr) begin
            retire_c   = 1'b1;
            state_next = bus.run ? ST_IF : ST_IDLE;
        end
    end

    assign bus.stateIF     = (state_reg == ST_IF);
    assign bus.stateID     = (state_reg == ST_ID);
    assign bus.stateEXE    = (state_reg == ST_EXE);
    assign bus.stateMEM    = (state_reg == ST_MEM);
    assign bus.stateWB     = (state_reg == ST_WB);
    assign bus.busy        = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign bus.halted      = (state_reg == ST_HALT);
    assign bus.illegal     = illegal_reg;
    assign bus.retire      = retire_c;
    assign bus.retired_cnt = cnt_reg;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed bench for stage_sequencer. Expected per-cycle
// records are pushed into a scoreboard queue as each cycle's stimulus is
// planned and popped when the DUT outputs for that cycle are sampled.
// A second instance with CNT_W = 4 shares the stimulus to exercise wrap.
module tb_stage_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stage_sequencer_if #(.CNT_W(32)) bus  ();
    stage_sequencer_if #(.CNT_W(4))  bus4 ();

    assign bus4.run       = bus.run;
    assign bus4.opcode    = bus.opcode;
    assign bus4.mem_ready = bus.mem_ready;

    stage_sequencer #(.CNT_W(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    stage_sequencer #(.CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        seq_state_t  st;
        logic        retire;
        logic        illegal;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_cnt;
    logic        model_ill;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    int          cyc_no = 0;

    localparam logic [6:0] OP_JUNK = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, expv);
        end
    endtask

    task automatic push(input seq_state_t st, input logic ret);
        exp_t e;
        e.st      = st;
        e.retire  = ret;
        e.illegal = model_ill;
        e.cnt     = model_cnt;
        sb_q.push_back(e);
        if (ret) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic compare_out();
        exp_t        e;
        logic [4:0]  s_exp;
        logic [4:0]  s_obs;
        if (sb_q.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL sb_empty cycle=%0d observed=0 entries expected>=1", cyc_no);
            return;
        end
        e = sb_q.pop_front();
        s_exp = {e.st == ST_IF, e.st == ST_ID, e.st == ST_EXE, e.st == ST_MEM, e.st == ST_WB};
        s_obs = {bus.stateIF, bus.stateID, bus.stateEXE, bus.stateMEM, bus.stateWB};
        check("strobes", 32'(s_obs), 32'(s_exp));
        check("busy",    32'(bus.busy),    32'(e.st != ST_IDLE && e.st != ST_HALT));
        check("halted",  32'(bus.halted),  32'(e.st == ST_HALT));
        check("illegal", 32'(bus.illegal), 32'(e.illegal));
        check("retire",  32'(bus.retire),  32'(e.retire));
        check("cnt32",   bus.retired_cnt,  e.cnt);
        check("cnt4",    32'(bus4.retired_cnt), {28'd0, e.cnt[3:0]});
        $display("cycle %0d state=%s strobes=%b retire=%b cnt=%0d cnt4=%0d",
                 cyc_no, e.st.name(), s_obs, bus.retire, bus.retired_cnt, bus4.retired_cnt);
    endtask

    // Apply inputs for one cycle, check that cycle's outputs, advance.
    task automatic cyc(input logic r, input logic [6:0] op, input logic mr);
        bus.run       = r;
        bus.opcode    = op;
        bus.mem_ready = mr;
        #1;
        compare_out();
        @(negedge clk);
        cyc_no++;
    endtask

    // One complete instruction starting in IF. opcode is only valid in ID;
    // junk is driven elsewhere so the latched copy must be what steers EXE/MEM.
    task automatic instr(input logic [6:0] op, input int waits, input logic run_mid,
                         input logic run_end);
        push(ST_IF, 1'b0);  cyc(1'b1, OP_JUNK, 1'b0);
        push(ST_ID, 1'b0);  cyc(1'b1, op, 1'b0);
        if (op == OP_BRANCH) begin
            push(ST_EXE, 1'b1); cyc(run_end, OP_JUNK, 1'b1);
        end else begin
            push(ST_EXE, 1'b0); cyc(run_mid, OP_JUNK, 1'b1);
            if (op == OP_LOAD || op == OP_STORE) begin
                for (int i = 0; i < waits; i++) begin
                    push(ST_MEM, 1'b0); cyc(run_mid, OP_JUNK, 1'b0);
                end
                if (op == OP_STORE) begin
                    push(ST_MEM, 1'b1); cyc(run_end, OP_JUNK, 1'b1);
                end else begin
                    push(ST_MEM, 1'b0); cyc(run_mid, OP_JUNK, 1'b1);
                end
            end
            if (op != OP_STORE) begin
                push(ST_WB, 1'b1); cyc(run_end, OP_JUNK, 1'b1);
            end
        end
    endtask

    task automatic instr_halt(input logic [6:0] op, input int halt_cycles);
        push(ST_IF, 1'b0); cyc(1'b1, OP_JUNK, 1'b0);
        push(ST_ID, 1'b0); cyc(1'b1, op, 1'b1);
        model_ill = (op != OP_SYSTEM);
        for (int i = 0; i < halt_cycles; i++) begin
            push(ST_HALT, 1'b0); cyc(logic'(i % 2), OP_RTYPE, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        model_cnt = 32'd0;
        model_ill = 1'b0;
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_RTYPE, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = 7'd0;
        bus.mem_ready = 1'b0;
        model_cnt     = 32'd0;
        model_ill     = 1'b0;
        @(negedge clk);

        // Reset state, then release.
        do_reset();

        // Back-to-back R-type: 4-cycle periods, count reaches 3.
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_RTYPE, 1'b0);
        repeat (3) instr(OP_RTYPE, 0, 1'b1, 1'b1);

        // Load with 3 wait cycles, store with no wait, then branch.
        instr(OP_LOAD, 3, 1'b1, 1'b1);
        instr(OP_STORE, 0, 1'b1, 1'b1);
        instr(OP_BRANCH, 0, 1'b1, 1'b1);

        // run dropped from EXE: WB still retires, then park in IDLE.
        instr(OP_RTYPE, 0, 1'b0, 1'b0);
        push(ST_IDLE, 1'b0); cyc(1'b0, OP_RTYPE, 1'b0);
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_RTYPE, 1'b0);
        instr(OP_IALU, 0, 1'b1, 1'b1);

        // Illegal opcode: HALT with illegal set; run toggling is ignored.
        instr_halt(OP_JUNK, 4);
        do_reset();

        // System opcode halts without the illegal flag.
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_RTYPE, 1'b0);
        instr_halt(OP_SYSTEM, 2);
        do_reset();

        // 16 retires wrap the 4-bit counter back to 0.
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_RTYPE, 1'b0);
        repeat (16) instr(OP_RTYPE, 0, 1'b1, 1'b1);

        // Reset asserted mid-MEM, away from any clock edge.
        push(ST_IF, 1'b0);  cyc(1'b1, OP_JUNK, 1'b0);
        push(ST_ID, 1'b0);  cyc(1'b1, OP_LOAD, 1'b0);
        push(ST_EXE, 1'b0); cyc(1'b1, OP_JUNK, 1'b0);
        push(ST_MEM, 1'b0); cyc(1'b1, OP_JUNK, 1'b0);
        bus.mem_ready = 1'b1;
        #2;
        rst_n     = 1'b0;
        model_cnt = 32'd0;
        model_ill = 1'b0;
        push(ST_IDLE, 1'b0);
        #1;
        compare_out();
        @(negedge clk);
        push(ST_IDLE, 1'b0); cyc(1'b1, OP_LOAD, 1'b1);
        rst_n = 1'b1;
        push(ST_IDLE, 1'b0); cyc(1'b0, OP_RTYPE, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
